// File: rtl/remote_comm_frame_pkg.sv
// Shared types and constants for the remote command framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package remote_comm_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_TX   = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  // Acknowledge byte that remote endpoints return on success.
  localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/remote_comm_frame.sv
// Serialises a CMD_BYTES-wide command MSB-first over a UART tx handshake, then optionally waits for a 1-byte response.
// Latency: snd_cmd -> trmt 1 cycle; tx_done -> next trmt 1 cycle; last tx_done -> cmd_snt 1 cycle; rx_rdy -> resp_vld 1 cycle.
// Backpressure: snd_cmd is only accepted in IDLE (busy=0); each byte waits for the UART's tx_done before the next is issued.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_snd_cmd, i_cmd               host request pulse and command word
//   o_busy, o_cmd_snt              frame in progress / last frame fully sent
//   o_resp_vld, o_resp, o_timeout  response capture pulse, byte, and wait-expired pulse
//   o_trmt, o_tx_data, i_tx_done   UART transmit handshake
//   i_rx_rdy, i_rx_data, o_clr_rx_rdy  UART receive handshake
module remote_comm_frame
  import remote_comm_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_EN     = 1,
  parameter int TO_W        = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_snd_cmd,
  input  logic [8*CMD_BYTES-1:0] i_cmd,
  output logic                   o_busy,
  output logic                   o_cmd_snt,
  output logic                   o_resp_vld,
  output logic [7:0]             o_resp,
  output logic                   o_timeout,
  output logic                   o_trmt,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  input  logic                   i_rx_rdy,
  input  logic [7:0]             i_rx_data,
  output logic                   o_clr_rx_rdy
);

  localparam int CNT_W = $clog2(CMD_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CMD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  state_t                 r_state;
  logic [8*CMD_BYTES-1:0] r_shift;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_cmd_snt;
  logic                   r_resp_vld;
  logic [7:0]             r_resp;
  logic                   r_timeout;
  logic                   r_trmt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_cmd_snt  <= 1'b0;
      r_resp_vld <= 1'b0;
      r_resp     <= 8'h00;
      r_timeout  <= 1'b0;
      r_trmt     <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_trmt     <= 1'b0;
      r_resp_vld <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_snd_cmd) begin
            r_shift    <= i_cmd;
            r_byte_cnt <= '0;
            r_cmd_snt  <= 1'b0;
            // trmt is raised on entry so it is high for the whole SEND cycle.
            r_trmt     <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          r_state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            if (r_byte_cnt < LAST_BYTE) begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_shift    <= r_shift << 8;
              r_trmt     <= 1'b1;
              r_state    <= SEND;
            end else begin
              r_cmd_snt <= 1'b1;
              if (RESP_EN != 0) begin
                r_to_cnt <= '0;
                r_state  <= WAIT_RESP;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        WAIT_RESP: begin
          // A response arriving on the final timeout cycle takes priority.
          if (i_rx_rdy) begin
            r_resp     <= i_rx_data;
            r_resp_vld <= 1'b1;
            r_state    <= IDLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_cmd_snt    = r_cmd_snt;
  assign o_resp_vld   = r_resp_vld;
  assign o_resp       = r_resp;
  assign o_timeout    = r_timeout;
  assign o_trmt       = r_trmt;
  assign o_tx_data    = r_shift[8*CMD_BYTES-1 -: 8];
  // Every received byte is acknowledged so strays outside WAIT_RESP are flushed.
  assign o_clr_rx_rdy = i_rx_rdy;

endmodule

// File: doc/remote_comm_frame.md
Name: remote_comm_frame

Overview:
Parametrised successor to the two-byte command sender. It serialises a CMD_BYTES-wide command, most-significant byte first, through an external UART's transmit handshake. Optionally it then waits for a one-byte response, with a cycle-count timeout. It sits between the host-side command source and the UART instance, and exposes the UART-side handshake signals as ports.

Parameters:
CMD_BYTES, 2, number of command bytes per frame (1..8)
RESP_EN, 1, 1 = wait for a response byte after the last byte is sent; 0 = return to IDLE immediately
TO_W, 20, width of the timeout counter
TIMEOUT_CYC, 1000000, cycles spent in WAIT_RESP before timeout fires (must be < 2**TO_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
snd_cmd  in  1  single-cycle request to send cmd
cmd  in  8*CMD_BYTES  command word; sampled only when snd_cmd is accepted
busy  out  1  high whenever state != IDLE
cmd_snt  out  1  level; set when the last byte's tx_done arrives, cleared on an accepted snd_cmd
resp_vld  out  1  one-cycle pulse; resp is valid this cycle and holds until the next capture
resp  out  8  captured response byte
timeout  out  1  one-cycle pulse when the response wait expires
trmt  out  1  one-cycle pulse to the UART to start transmitting tx_data
tx_data  out  8  byte presented to the UART
tx_done  in  1  UART byte-complete pulse
rx_rdy  in  1  UART receive-byte-ready level
rx_data  in  8  UART received byte
clr_rx_rdy  out  1  clears the UART's rx_rdy

Behaviour:
- Reset values: busy=0, cmd_snt=0, resp_vld=0, resp=8'h00, timeout=0, trmt=0, tx_data=8'h00, clr_rx_rdy=0. State goes to IDLE; shift register, byte counter and timeout counter go to 0.
- Reset asserted mid-frame aborts the frame immediately; the UART may finish its current byte, and its tx_done is ignored in IDLE.
- States and transitions:
  - IDLE: on snd_cmd, load cmd into the shift register, set byte_cnt=0, clear cmd_snt, go to SEND. snd_cmd in any other state is ignored (no re-latch, cmd_snt unchanged).
  - SEND: assert trmt for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: on tx_done:
    - If byte_cnt < CMD_BYTES-1: byte_cnt+1, shift left 8, go to SEND.
    - Otherwise: set cmd_snt. If RESP_EN, clear the timeout counter and go to WAIT_RESP; if not, go to IDLE.
  - WAIT_RESP:
    - On rx_rdy: resp<=rx_data, pulse resp_vld, go to IDLE.
    - Otherwise, when the counter reaches TIMEOUT_CYC-1: pulse timeout, go to IDLE.
    - Otherwise the counter increments each cycle.
- tx_data is always the top byte of the shift register, held stable from SEND through the following tx_done.
- Latency: snd_cmd at cycle 0 gives trmt at cycle 1 with tx_data = cmd[8*CMD_BYTES-1 -: 8]. tx_done at cycle t gives the next trmt at t+1. The last tx_done at t gives cmd_snt=1 at t+1.
- A frame takes exactly CMD_BYTES trmt pulses.
- rx_rdy captured in WAIT_RESP at cycle t gives resp_vld=1 and resp valid at t+1.
- clr_rx_rdy = rx_rdy, combinationally, in every state. Stray bytes outside WAIT_RESP are flushed and not captured, and resp_vld does not pulse for them.
- Simultaneous rx_rdy and the final timeout cycle: the response wins; timeout does not pulse.
- tx_done in IDLE, SEND or WAIT_RESP is ignored.
- A new snd_cmd is accepted the first cycle after returning to IDLE.
- The byte counter width is $clog2(CMD_BYTES)+1 (at least 1 bit). There is no wrap-around because the counter resets per frame.

Decomposition:
- Shared package remote_comm_pkg holds:
  - state_t enum {IDLE, SEND, WAIT_TX, WAIT_RESP} as logic [1:0]
  - constant RESP_ACK = 8'hA5, used by integrators and by the bench
- No sub-module: the shift register, byte counter and timeout counter stay inline.
- The integrating top instantiates the existing UART next to this block; the UART is not instantiated inside it.

Test Plan:
- Default parameters, cmd=16'hABCD, snd_cmd pulse, UART model with tx_done 10 cycles after each trmt -> trmt pulses carry tx_data 8'hAB then 8'hCD; cmd_snt rises 1 cycle after the second tx_done; exactly 2 trmt pulses.
- CMD_BYTES=4, RESP_EN=0, cmd=32'h1234_5678 -> bytes 12, 34, 56, 78 in order; busy drops 1 cycle after the last tx_done; resp_vld and timeout never pulse.
- RESP_EN=1, rx_rdy with rx_data=8'hA5 20 cycles after the last tx_done -> resp_vld pulses 1 cycle later with resp=8'hA5; clr_rx_rdy high in the rx_rdy cycle; state is IDLE.
- TIMEOUT_CYC=16, no response -> timeout pulses on the 16th WAIT_RESP cycle; resp is unchanged. Repeat with rx_rdy on exactly that cycle -> resp_vld pulses and timeout stays 0.
- snd_cmd with cmd=16'h5555 issued during WAIT_TX of a 16'hABCD frame -> still exactly 2 bytes, AB and CD; cmd_snt is not cleared mid-frame. A stray rx_rdy (8'h77) while in IDLE -> clr_rx_rdy pulses; resp and resp_vld unchanged.
- rst_n dropped while in WAIT_TX after the first byte -> all outputs return to reset values asynchronously. A late tx_done after reset produces no trmt. A fresh snd_cmd then sends a complete frame.
